// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter: controller state and requester count.
// Optional write-to-read forwarding is enabled by defining BRAM_ARB_WR_FWD_EN.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } arb_state_e;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/bram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: grants the lone requester, or the one named by
// prio when both ask, and hands back the priority to use on the next cycle.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               prio,
  output logic [NUM_REQ-1:0] gnt,
  output logic               prio_nxt
);

  // Only a contested grant moves the priority, and it moves to the loser.
  always_comb begin
    gnt      = '0;
    prio_nxt = prio;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        gnt      = prio ? 2'b10 : 2'b01;
        prio_nxt = ~prio;
      end
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple dual-port byte-write BRAM between two requesters, clearing
// it after reset. Define BRAM_ARB_WR_FWD_EN to forward same-cycle write data.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int LEN_DATA = 32,
  parameter int LEN_ADDR = 10
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*LEN_ADDR-1:0]     req_addr_i,
  input  logic [NUM_REQ*(LEN_DATA/8)-1:0] req_wstrb_i,
  input  logic [NUM_REQ*LEN_DATA-1:0]     req_wdata_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [LEN_DATA-1:0]             rsp_rdata_o,
  output logic                            init_done_o,
  output logic                            bram_ena_o,
  output logic [LEN_DATA/8-1:0]           bram_wea_o,
  output logic [LEN_ADDR-1:0]             bram_addra_o,
  output logic [LEN_DATA-1:0]             bram_dina_o,
  output logic                            bram_enb_o,
  output logic [LEN_ADDR-1:0]             bram_addrb_o,
  input  logic [LEN_DATA-1:0]             bram_doutb_i
);

  localparam int NSTRB = LEN_DATA / 8;

  arb_state_e state, state_nxt;
  logic [LEN_ADDR-1:0] cnt;
  logic                wr_prio, wr_prio_nxt;
  logic                rd_prio, rd_prio_nxt;
  logic                run;

  logic [LEN_ADDR-1:0] addr  [NUM_REQ];
  logic [NSTRB-1:0]    strb  [NUM_REQ];
  logic [LEN_DATA-1:0] wdata [NUM_REQ];
  logic [NUM_REQ-1:0]  wr_req, rd_req, wr_gnt, rd_gnt;
  logic                wr_sel, rd_sel;

  assign run = (state == RUN);

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr[k]   = req_addr_i[k*LEN_ADDR +: LEN_ADDR];
    assign strb[k]   = req_wstrb_i[k*NSTRB +: NSTRB];
    assign wdata[k]  = req_wdata_i[k*LEN_DATA +: LEN_DATA];
    assign wr_req[k] = run & req_valid_i[k] & (|strb[k]);
    assign rd_req[k] = run & req_valid_i[k] & ~(|strb[k]);
  end

  rr_arb2 u_wr_arb (
    .req      (wr_req),
    .prio     (wr_prio),
    .gnt      (wr_gnt),
    .prio_nxt (wr_prio_nxt)
  );

  rr_arb2 u_rd_arb (
    .req      (rd_req),
    .prio     (rd_prio),
    .gnt      (rd_gnt),
    .prio_nxt (rd_prio_nxt)
  );

  assign wr_sel      = wr_gnt[1];
  assign rd_sel      = rd_gnt[1];
  assign req_ready_o = wr_gnt | rd_gnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= RST;
      cnt         <= '0;
      wr_prio     <= 1'b0;
      rd_prio     <= 1'b0;
      rsp_valid_o <= '0;
      init_done_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_prio     <= wr_prio_nxt;
      rd_prio     <= rd_prio_nxt;
      rsp_valid_o <= rd_gnt;
      init_done_o <= (state_nxt == RUN);
      if (state == INIT) begin
        cnt <= cnt + LEN_ADDR'(1);
      end
    end
  end

  // Clear sweeps every address once, then the controller stays in RUN.
  always_comb begin
    state_nxt    = state;
    bram_ena_o   = 1'b0;
    bram_wea_o   = '0;
    bram_addra_o = '0;
    bram_dina_o  = '0;
    bram_enb_o   = 1'b0;
    bram_addrb_o = '0;
    case (state)
      RST: state_nxt = INIT;
      INIT: begin
        bram_ena_o   = 1'b1;
        bram_wea_o   = '1;
        bram_addra_o = cnt;
        if (cnt == '1) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (|wr_gnt) begin
          bram_ena_o   = 1'b1;
          bram_wea_o   = strb[wr_sel];
          bram_addra_o = addr[wr_sel];
          bram_dina_o  = wdata[wr_sel];
        end
        if (|rd_gnt) begin
          bram_enb_o   = 1'b1;
          bram_addrb_o = addr[rd_sel];
        end
      end
      default: state_nxt = RST;
    endcase
  end

`ifdef BRAM_ARB_WR_FWD_EN
  logic                fwd_hit_q;
  logic [NSTRB-1:0]    fwd_strb_q;
  logic [LEN_DATA-1:0] fwd_data_q;

  // The BRAM is read-first, so a colliding write is remembered for one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fwd_hit_q  <= 1'b0;
      fwd_strb_q <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= (|wr_gnt) & (|rd_gnt) & (bram_addra_o == bram_addrb_o);
      fwd_strb_q <= bram_wea_o;
      fwd_data_q <= bram_dina_o;
    end
  end

  always_comb begin
    rsp_rdata_o = bram_doutb_i;
    if (fwd_hit_q) begin
      for (int b = 0; b < NSTRB; b++) begin
        if (fwd_strb_q[b]) begin
          rsp_rdata_o[8*b +: 8] = fwd_data_q[8*b +: 8];
        end
      end
    end
  end
`else
  assign rsp_rdata_o = bram_doutb_i;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios plus random
// traffic, compared against a behavioural memory/arbitration reference model.
module tb_bram_port_arbiter;

  localparam int LD    = 32;
  localparam int LA    = 10;
  localparam int DEPTH = 1 << LA;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    req_valid_i;
  logic [1:0]    req_ready_o;
  logic [2*LA-1:0] req_addr_i;
  logic [7:0]    req_wstrb_i;
  logic [63:0]   req_wdata_i;
  logic [1:0]    rsp_valid_o;
  logic [LD-1:0] rsp_rdata_o;
  logic          init_done_o;
  logic          bram_ena_o;
  logic [3:0]    bram_wea_o;
  logic [LA-1:0] bram_addra_o;
  logic [LD-1:0] bram_dina_o;
  logic          bram_enb_o;
  logic [LA-1:0] bram_addrb_o;
  logic [LD-1:0] bram_doutb_i;

  int checks = 0;
  int errors = 0;

  bram_port_arbiter #(.LEN_DATA(LD), .LEN_ADDR(LA)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_wstrb_i  (req_wstrb_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .init_done_o  (init_done_o),
    .bram_ena_o   (bram_ena_o),
    .bram_wea_o   (bram_wea_o),
    .bram_addra_o (bram_addra_o),
    .bram_dina_o  (bram_dina_o),
    .bram_enb_o   (bram_enb_o),
    .bram_addrb_o (bram_addrb_o),
    .bram_doutb_i (bram_doutb_i)
  );

  always #5 clk = ~clk;

  // Read-first BRAM, preloaded with garbage so the clear sweep is visible.
  logic [LD-1:0] bramMem [DEPTH];
  logic          seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) bramMem[i] <= $urandom;
      seeded <= 1'b1;
    end else begin
      if (bram_ena_o)
        for (int b = 0; b < 4; b++)
          if (bram_wea_o[b]) bramMem[bram_addra_o][8*b +: 8] <= bram_dina_o[8*b +: 8];
      if (bram_enb_o) bram_doutb_i <= bramMem[bram_addrb_o];
    end
  end

  // Reference model state: expected memory contents, priorities, pending response.
  logic [LD-1:0] refMem [DEPTH];
  logic          wrPrio, rdPrio;
  logic [1:0]    expRspValid;
  logic [LD-1:0] expRspData;

  task automatic checkVal(input string tag, input logic [LD-1:0] obs, input logic [LD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] c, input logic p);
    if (c == 2'b11) return p ? 2'b10 : 2'b01;
    return c;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    wrPrio      = 1'b0;
    rdPrio      = 1'b0;
    expRspValid = 2'b00;
    expRspData  = '0;
  endtask

  task automatic checkOutput();
    checkVal("rsp_valid", {30'd0, rsp_valid_o}, {30'd0, expRspValid});
    if (expRspValid != 2'b00) checkVal("rsp_rdata", rsp_rdata_o, expRspData);
  endtask

  // One cycle of requests: check the previous response, the grants, then advance the model.
  task automatic applyStimulus(input logic [1:0] v, input logic [LA-1:0] a0, input logic [LA-1:0] a1,
                               input logic [3:0] s0, input logic [3:0] s1,
                               input logic [LD-1:0] d0, input logic [LD-1:0] d1,
                               output logic [1:0] rdy);
    logic [1:0]    wc, rc, wg, rg;
    logic [LA-1:0] wa, ra;
    logic [3:0]    ws;
    logic [LD-1:0] wd, nd;
    @(negedge clk);
    req_valid_i = v;
    req_addr_i  = {a1, a0};
    req_wstrb_i = {s1, s0};
    req_wdata_i = {d1, d0};
    #1;
    checkOutput();
    wc = {v[1] && s1 != 0, v[0] && s0 != 0};
    rc = {v[1] && s1 == 0, v[0] && s0 == 0};
    wg = pick(wc, wrPrio);
    rg = pick(rc, rdPrio);
    checkVal("req_ready", {30'd0, req_ready_o}, {30'd0, wg | rg});
    rdy = req_ready_o;
    wa = wg[1] ? a1 : a0;
    ws = wg[1] ? s1 : s0;
    wd = wg[1] ? d1 : d0;
    ra = rg[1] ? a1 : a0;
    nd = '0;
    if (rg != 2'b00) begin
      nd = refMem[ra];
`ifdef BRAM_ARB_WR_FWD_EN
      if (wg != 2'b00 && wa == ra)
        for (int b = 0; b < 4; b++) if (ws[b]) nd[8*b +: 8] = wd[8*b +: 8];
`endif
    end
    if (wg != 2'b00)
      for (int b = 0; b < 4; b++) if (ws[b]) refMem[wa][8*b +: 8] = wd[8*b +: 8];
    if (wc == 2'b11) wrPrio = ~wrPrio;
    if (rc == 2'b11) rdPrio = ~rdPrio;
    expRspValid = rg;
    expRspData  = nd;
  endtask

  // Releases reset and measures the clear sweep while both requesters keep asking.
  task automatic runInit();
    int   cyc;
    logic readyLeak, clearOk;
    cyc = 0; readyLeak = 1'b0; clearOk = 1'b1;
    @(negedge clk);
    resetn      = 1'b1;
    req_valid_i = 2'b11;
    req_wstrb_i = '0;
    while (init_done_o !== 1'b1 && cyc < DEPTH + 50) begin
      @(posedge clk);
      #1;
      cyc++;
      if (init_done_o !== 1'b1) begin
        if (req_ready_o !== 2'b00) readyLeak = 1'b1;
        if (bram_ena_o !== 1'b1 || bram_wea_o !== 4'hF || bram_addra_o !== LA'(cyc - 1) ||
            bram_dina_o !== '0 || bram_enb_o !== 1'b0) clearOk = 1'b0;
      end
    end
    req_valid_i = 2'b00;
    checkVal("init_done_cycle", LD'(cyc), LD'(DEPTH + 1));
    checkVal("init_done_high", {31'd0, init_done_o}, 32'd1);
    checkVal("ready_during_init", {31'd0, readyLeak}, 32'd0);
    checkVal("clear_sweep", {31'd0, clearOk}, 32'd1);
    modelReset();
  endtask

  task automatic readAll();
    logic [1:0] r;
    for (int a = 0; a < DEPTH; a++) applyStimulus(2'b01, LA'(a), '0, 4'h0, 4'h0, '0, '0, r);
    applyStimulus(2'b00, '0, '0, 4'h0, 4'h0, '0, '0, r);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]    r;
    logic [LD-1:0] x5, x9, p0, p1;
    logic [1:0]    pv;
    logic [LA-1:0] pa [2];
    logic [3:0]    ps [2];
    logic [LD-1:0] pd [2];

    resetn = 1'b0; req_valid_i = '0; req_addr_i = '0; req_wstrb_i = '0; req_wdata_i = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_ready", {30'd0, req_ready_o}, 32'd0);
    checkVal("rst_rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
    checkVal("rst_init_done", {31'd0, init_done_o}, 32'd0);
    checkVal("rst_bram_en", {28'd0, bram_ena_o, bram_enb_o, 2'b00}, 32'd0);
    checkVal("rst_bram_wea", {28'd0, bram_wea_o}, 32'd0);
    checkVal("rst_bram_addr", {12'd0, bram_addra_o, bram_addrb_o}, 32'd0);

    runInit();
    readAll();

    // Two contested reads streams after preloading addresses 5 and 9.
    x5 = $urandom; x9 = $urandom;
    applyStimulus(2'b11, 10'd5, 10'd9, 4'hF, 4'hF, x5, x9, r);
    checkVal("preload_gnt0", {30'd0, r}, 32'd1);
    applyStimulus(2'b10, 10'd0, 10'd9, 4'h0, 4'hF, '0, x9, r);
    checkVal("preload_gnt1", {30'd0, r}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 10'd5, 10'd9, 4'h0, 4'h0, '0, '0, r);
      checkVal("rd_alternate", {30'd0, r}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    applyStimulus(2'b00, '0, '0, 4'h0, 4'h0, '0, '0, r);
    checkVal("rd_last_rsp", rsp_rdata_o, x9);

    // Partial-strobe merge over an older value.
    applyStimulus(2'b01, 10'd3, '0, 4'hF, 4'h0, 32'h11223344, '0, r);
    applyStimulus(2'b01, 10'd3, '0, 4'b0101, 4'h0, 32'hAABBCCDD, '0, r);
    applyStimulus(2'b10, '0, 10'd3, 4'h0, 4'h0, '0, '0, r);
    applyStimulus(2'b00, '0, '0, 4'h0, 4'h0, '0, '0, r);
    checkVal("strobe_merge", rsp_rdata_o, 32'h11BB33DD);
    checkVal("strobe_merge_vld", {30'd0, rsp_valid_o}, 32'd2);

    // Same-cycle write and read of one address.
    applyStimulus(2'b11, 10'd7, 10'd7, 4'hF, 4'h0, 32'hDEADBEEF, '0, r);
    checkVal("collide_gnt", {30'd0, r}, 32'd3);
    applyStimulus(2'b00, '0, '0, 4'h0, 4'h0, '0, '0, r);
`ifdef BRAM_ARB_WR_FWD_EN
    checkVal("collide_data", rsp_rdata_o, 32'hDEADBEEF);
`else
    checkVal("collide_data", rsp_rdata_o, 32'h00000000);
`endif

    // Contested writes to one address in consecutive cycles.
    p0 = $urandom; p1 = $urandom;
    applyStimulus(2'b11, 10'd20, 10'd20, 4'hF, 4'hF, p0, p1, r);
    checkVal("ww_gnt_first", {30'd0, r}, 32'd2);
    applyStimulus(2'b11, 10'd20, 10'd20, 4'hF, 4'hF, p0, p1, r);
    checkVal("ww_gnt_second", {30'd0, r}, 32'd1);
    applyStimulus(2'b01, 10'd20, '0, 4'h0, 4'h0, '0, '0, r);
    applyStimulus(2'b00, '0, '0, 4'h0, 4'h0, '0, '0, r);
    checkVal("ww_final", rsp_rdata_o, p0);

    // Random traffic; a requester holds its request until it is granted.
    pv = 2'b00;
    for (int i = 0; i < 2; i++) begin pa[i] = '0; ps[i] = '0; pd[i] = '0; end
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pv[k] && $urandom_range(0, 9) < 7) begin
          pv[k] = 1'b1;
          pa[k] = LA'($urandom_range(0, 15));
          ps[k] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          pd[k] = $urandom;
        end
      end
      applyStimulus(pv, pa[0], pa[1], ps[0], ps[1], pd[0], pd[1], r);
      pv = pv & ~r;
    end
    applyStimulus(2'b00, '0, '0, 4'h0, 4'h0, '0, '0, r);

    // Reset lands before the granted read can return.
    applyStimulus(2'b01, 10'd5, '0, 4'h0, 4'h0, '0, '0, r);
    checkVal("midrst_gnt", {30'd0, r}, 32'd1);
    resetn = 1'b0;
    req_valid_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkVal("midrst_rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
    end
    checkVal("midrst_init_done", {31'd0, init_done_o}, 32'd0);
    runInit();
    readAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
